dmem_arbiter: RTL

Sequences the single-port data memory and shares it between the CPU MEM stage and a DMA/debug requester. Round-robin arbitration, multi-cycle access with a down-counter, and a stall output back to the pipeline while a CPU access is pending. Sits between the MEM-stage address/write-data signals and the data memory.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_rr_pick.sv | 32 +++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory arbiter
//
// Purpose: FSM state and access-owner encodings used by dmem_arbiter and
// dmem_rr_pick.
// Contents: state_t (IDLE/BUSY/DONE), owner_t (OWN_CPU/OWN_DMA).

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational 2-way round-robin pick
//
// Purpose: choose between the CPU and DMA requesters. A lone requester
// always wins; on a tie the requester not served last wins.
// Ports:
//   cpu_req     in  : CPU request
//   dma_req     in  : DMA/debug request
//   last_dma    in  : 1 when the DMA owned the most recent completed access
//   grant_valid out : at least one request present
//   grant_owner out : chosen owner (meaningful only with grant_valid)

module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   last_dma,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_owner = OWN_CPU;
        if (cpu_req && dma_req) begin
            grant_owner = last_dma ? OWN_CPU : OWN_DMA;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory sequencer shared by CPU and DMA
//
// Purpose: grants the data memory to the CPU MEM stage or a DMA/debug
// requester (round-robin on ties), holds the memory interface for MEM_LAT
// BUSY cycles, then pulses the owner's done for one cycle. Requests are
// sampled only in IDLE; the IDLE bubble between accesses is mandatory.
// Configuration: define DMEM_ARB_FAST_WRITE_EN to give writes a single BUSY
// cycle regardless of MEM_LAT (reads unchanged).
// Ports:
//   clk_i, rst_i               : clock, async active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i : CPU request (level, held until done)
//   cpu_stall_o                : cpu_req_i & ~cpu_done_o
//   cpu_done_o, cpu_rdata_o    : completion pulse, registered load data
//   dma_req_i/we_i/addr_i/wdata_i, dma_done_o, dma_rdata_o : same for DMA
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o : memory request
//   mem_rdata_i                : memory read data, valid in last BUSY cycle

module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic              cpu_done_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_done_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    import dmem_arb_pkg::*;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              last_dma_q, last_dma_d;

    logic              grant_valid;
    owner_t            grant_owner;
    logic              grant_we;

    dmem_rr_pick u_pick (
        .cpu_req     (cpu_req_i),
        .dma_req     (dma_req_i),
        .last_dma    (last_dma_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant_we = (grant_owner == OWN_DMA) ? dma_we_i : cpu_we_i;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        last_dma_d  = last_dma_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    we_d    = grant_we;
                    addr_d  = (grant_owner == OWN_DMA) ? dma_addr_i  : cpu_addr_i;
                    wdata_d = (grant_owner == OWN_DMA) ? dma_wdata_i : cpu_wdata_i;
`ifdef DMEM_ARB_FAST_WRITE_EN
                    cnt_d   = grant_we ? '0 : CNT_LOAD;
`else
                    cnt_d   = CNT_LOAD;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Read data is only valid in the final BUSY cycle.
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) begin
                            dma_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                last_dma_d = (owner_q == OWN_DMA);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            last_dma_q  <= 1'b1;   // CPU wins the first tie
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            last_dma_q  <= last_dma_d;
        end
    end

    assign mem_en_o    = (state_q == BUSY);
    assign mem_we_o    = mem_en_o & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign cpu_done_o  = (state_q == DONE) && (owner_q == OWN_CPU);
    assign dma_done_o  = (state_q == DONE) && (owner_q == OWN_DMA);
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;

    assign cpu_stall_o = cpu_req_i & ~cpu_done_o;

endmodule
